sap_control_sequencer: RTL and testbench

- Microcoded control unit for the SAP-1 datapath. It drives the bus-enable, latch and ALU control lines that are currently driven by hand through virtual I/O sources.
- Consumes the instruction-register opcode and the ALU C/Z flags. Produces one control word per T-state.
- Advances one T-state per step pulse from the clock pulser, so the datapath registers clocked by that pulse see a stable control word.

---
 rtl/sap_control_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// SAP-1 microcoded control sequencer: one control word per T-state,
// advancing on the clock-pulser step strobe.
module sap_control_sequencer #(
    parameter int NUM_T = 5,
    parameter int OP_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step,
    input  logic [OP_W-1:0] opcode,
    input  logic            alu_c,
    input  logic            alu_z,
    output logic            pc_out,
    output logic            pc_inc,
    output logic            pc_jump,
    output logic            mar_in,
    output logic            ram_in,
    output logic            ram_out,
    output logic            ir_in,
    output logic            ir_out,
    output logic            a_in,
    output logic            a_out,
    output logic            b_in,
    output logic            alu_out,
    output logic            alu_sub,
    output logic            o_in,
    output logic [2:0]      t_state,
    output logic            carry_flag,
    output logic            zero_flag,
    output logic            halted
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_STA = 4'd4,
        OP_LDI = 4'd5,
        OP_JMP = 4'd6,
        OP_JC  = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } op_e;

    localparam logic [2:0] T_LAST = 3'(NUM_T - 1);

    tstate_e    state, state_nx;
    logic       carry_nx, zero_nx, halted_nx;
    logic       last, flag_ld, halt_set;
    logic [3:0] op;

    assign op      = 4'(opcode);
    assign t_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= T0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nx;
            carry_flag <= carry_nx;
            zero_flag  <= zero_nx;
            halted     <= halted_nx;
        end
    end

    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        mar_in   = 1'b0;
        ram_in   = 1'b0;
        ram_out  = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        o_in     = 1'b0;
        last     = 1'b0;
        flag_ld  = 1'b0;
        halt_set = 1'b0;

        if (!halted) begin
            unique case (state)
                T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    last = 1'b1;
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                            last   = 1'b0;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_jump = 1'b1;
                        end
                        OP_JC: begin
                            ir_out  = carry_flag;
                            pc_jump = carry_flag;
                        end
                        OP_JZ: begin
                            ir_out  = zero_flag;
                            pc_jump = zero_flag;
                        end
                        OP_OUT: begin
                            a_out = 1'b1;
                            o_in  = 1'b1;
                        end
                        OP_HLT: halt_set = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    last = 1'b1;
                    case (op)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                            alu_sub = (op == OP_SUB);
                            last    = 1'b0;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    last = 1'b1;
                    if (op == OP_ADD || op == OP_SUB) begin
                        alu_out = 1'b1;
                        a_in    = 1'b1;
                        alu_sub = (op == OP_SUB);
                        flag_ld = 1'b1;
                    end
                end
                default: last = 1'b1;
            endcase
        end

        state_nx  = state;
        carry_nx  = carry_flag;
        zero_nx   = zero_flag;
        halted_nx = halted;
        if (step && !halted) begin
            if (halt_set) begin
                halted_nx = 1'b1;
            end else begin
                // Opcode-defined last step or the T-state ceiling both wrap.
                if (last || state == T_LAST)
                    state_nx = T0;
                else
                    state_nx = tstate_e'(state + 3'd1);
                if (flag_ld) begin
                    carry_nx = alu_c;
                    zero_nx  = alu_z;
                end
            end
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: microcode-table model checked every
// cycle plus directed literal expectations.
module tb_sap_control_sequencer;

    localparam logic [13:0] PO = 14'h2000, CE = 14'h1000, J  = 14'h0800;
    localparam logic [13:0] MI = 14'h0400, RI = 14'h0200, RO = 14'h0100;
    localparam logic [13:0] II = 14'h0080, IO = 14'h0040, AI = 14'h0020;
    localparam logic [13:0] AO = 14'h0010, BI = 14'h0008, EO = 14'h0004;
    localparam logic [13:0] SU = 14'h0002, OI = 14'h0001;

    logic       clk = 1'b0;
    logic       rst_n, step, alu_c, alu_z;
    logic [3:0] opcode;
    logic       pc_out, pc_inc, pc_jump, mar_in, ram_in, ram_out, ir_in;
    logic       ir_out, a_in, a_out, b_in, alu_out, alu_sub, o_in;
    logic [2:0] t_state;
    logic       carry_flag, zero_flag, halted;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    sap_control_sequencer #(.NUM_T(5), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .opcode(opcode),
        .alu_c(alu_c), .alu_z(alu_z),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_jump(pc_jump),
        .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out),
        .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in), .a_out(a_out),
        .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub), .o_in(o_in),
        .t_state(t_state), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [13:0] cw;
    assign cw = {pc_out, pc_inc, pc_jump, mar_in, ram_in, ram_out, ir_in,
                 ir_out, a_in, a_out, b_in, alu_out, alu_sub, o_in};

    // Model: execute microcode table per opcode plus program-level state.
    logic [13:0] uc [16][3];
    int          ln [16];
    int          m_t;
    bit          m_c, m_z, m_h;

    initial begin
        for (int o = 0; o < 16; o++) begin
            ln[o] = 1;
            for (int k = 0; k < 3; k++) uc[o][k] = '0;
        end
        uc[1][0] = IO | MI;  uc[1][1] = RO | AI;  ln[1] = 2;
        uc[2][0] = IO | MI;  uc[2][1] = RO | BI;  uc[2][2] = EO | AI;
        ln[2] = 3;
        uc[3][0] = IO | MI;  uc[3][1] = RO | BI | SU;
        uc[3][2] = EO | AI | SU;  ln[3] = 3;
        uc[4][0] = IO | MI;  uc[4][1] = AO | RI;  ln[4] = 2;
        uc[5][0] = IO | AI;
        uc[6][0] = IO | J;
        uc[7][0] = IO | J;
        uc[8][0] = IO | J;
        uc[14][0] = AO | OI;
    end

    function automatic logic [13:0] exp_word();
        logic [13:0] w;
        int k;
        if (m_h) return '0;
        if (m_t == 0) return PO | MI;
        if (m_t == 1) return RO | II | CE;
        k = m_t - 2;
        if (k >= ln[opcode]) return '0;
        w = uc[opcode][k];
        if (opcode == 4'd7 && !m_c) w = '0;
        if (opcode == 4'd8 && !m_z) w = '0;
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_c = 0; m_z = 0; m_h = 0;
        end else if (step && !m_h) begin
            if (m_t == 2 && opcode == 4'd15) begin
                m_h = 1;
            end else begin
                if (m_t == 4 && (opcode == 4'd2 || opcode == 4'd3)) begin
                    m_c = alu_c;
                    m_z = alu_z;
                end
                if (m_t == 4 || (m_t >= 2 && m_t - 2 >= ln[opcode] - 1))
                    m_t = 0;
                else
                    m_t = m_t + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cw", 32'(cw), 32'(exp_word()));
            check("t_state", 32'(t_state), 32'(m_t));
            check("carry", 32'(carry_flag), 32'(m_c));
            check("zero", 32'(zero_flag), 32'(m_z));
            check("halted", 32'(halted), 32'(m_h));
            check("one_driver",
                  32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1),
                  32'd1);
            assert ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1)
                else $error("bus has more than one driver");
        end
    end

    task automatic step_once();
        @(negedge clk); #1 step = 1'b1;
        @(negedge clk); #1 step = 1'b0;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step_once();
    endtask

    task automatic mid_reset();
        @(negedge clk); #3 rst_n = 1'b0;
        #1;
        check("rst_t", 32'(t_state), 32'd0);
        check("rst_c", 32'(carry_flag), 32'd0);
        check("rst_z", 32'(zero_flag), 32'd0);
        check("rst_h", 32'(halted), 32'd0);
        check("rst_cw", 32'(cw), 32'(PO | MI));
        step = 1'b1;
        @(negedge clk); #1;
        check("rst_step_ign", 32'(t_state), 32'd0);
        step = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; step = 1'b0; opcode = 4'd1; alu_c = 1'b0; alu_z = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk); #1 rst_n = 1'b1;
        check("pin_t0_cw", 32'(cw), 32'(PO | MI));
        check("pin_t0_t", 32'(t_state), 32'd0);

        step_once();
        check("pin_t1_cw", 32'(cw), 32'(RO | II | CE));
        step_once();
        check("pin_t2_t", 32'(t_state), 32'd2);
        check("pin_lda_t2", 32'(cw), 32'(IO | MI));
        step_once();
        check("pin_lda_t3", 32'(cw), 32'(RO | AI));
        step_once();
        check("pin_lda_wrap", 32'(t_state), 32'd0);

        opcode = 4'd2; alu_c = 1'b1; alu_z = 1'b0;
        step_n(5);
        check("pin_add_c", 32'(carry_flag), 32'd1);
        check("pin_add_z", 32'(zero_flag), 32'd0);
        check("pin_add_wrap", 32'(t_state), 32'd0);

        opcode = 4'd3; alu_c = 1'b0; alu_z = 1'b1;
        step_n(3);
        check("pin_sub_t3", 32'(cw), 32'(RO | BI | SU));
        step_once();
        check("pin_sub_t4", 32'(cw), 32'(EO | AI | SU));
        step_once();
        check("pin_sub_c", 32'(carry_flag), 32'd0);
        check("pin_sub_z", 32'(zero_flag), 32'd1);

        opcode = 4'd7;
        step_n(2);
        check("pin_jc0_cw", 32'(cw), 32'd0);
        step_once();
        check("pin_jc0_wrap", 32'(t_state), 32'd0);

        opcode = 4'd2; alu_c = 1'b1; alu_z = 1'b0;
        step_n(5);
        opcode = 4'd7;
        step_n(2);
        check("pin_jc1_cw", 32'(cw), 32'(IO | J));
        step_once();

        opcode = 4'd15;
        step_n(3);
        check("pin_hlt_h", 32'(halted), 32'd1);
        check("pin_hlt_cw", 32'(cw), 32'd0);
        check("pin_hlt_t", 32'(t_state), 32'd2);
        step_n(10);
        check("pin_hlt_hold", 32'(t_state), 32'd2);
        mid_reset();
        check("pin_hlt_clr", 32'(halted), 32'd0);

        for (int i = 0; i < 40; i++) begin
            opcode = 4'($urandom_range(0, 15));
            alu_c = 1'($urandom);
            alu_z = 1'($urandom);
            for (int k = 0; k < 6; k++) begin
                step_once();
                if (halted) break;
                if (t_state == 3'd3 && (i % 3 == 0)) begin
                    mid_reset();
                    break;
                end
                if (t_state == 3'd0) break;
            end
            if (halted) mid_reset();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
